// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit: redirect encodings, FSM states,
// and immediate sign extension.
package pc_pkg;

    // Redirect mode encodings; any other value on redir_mode means "no redirect".
    localparam logic [1:0] PC_IMM = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;

    // Widest XLEN the sign-extension helper supports.
    localparam int SEXT_W = 64;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Sign-extend the low 'width' bits of value to SEXT_W bits.
    // Callers slice the result down to their own XLEN.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] value,
                                               input int unsigned width);
        logic signed [SEXT_W-1:0] tmp;
        tmp = value << (SEXT_W - width);
        return tmp >>> (SEXT_W - width);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation and alignment check.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int IMM_W     = 32,
    parameter int ALIGN_LSB = 2
) (
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] rs_val,
    input  logic [IMM_W-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [SEXT_W-1:0] imm_wide;
    logic [XLEN-1:0]   imm_ext;

    assign imm_wide = sext(SEXT_W'(imm), IMM_W);
    assign imm_ext  = imm_wide[XLEN-1:0];

    // Target is base-relative by default; register-relative jumps drop bit0
    // before the alignment test.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        target = base + imm_ext;
        if (mode == PC_REG) begin
            target    = rs_val + imm_ext;
            target[0] = 1'b0;
        end
        misaligned = |target[ALIGN_LSB-1:0];
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC unit: holds the fetch address, advances sequentially, applies
// branch/jump redirects, buffers redirects across stalls, and traps on
// misaligned targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter int              IMM_W     = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              ALIGN_LSB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [1:0]       redir_mode,
    input  logic [XLEN-1:0]  redir_base,
    input  logic [XLEN-1:0]  redir_reg,
    input  logic [IMM_W-1:0] redir_imm,
    input  logic             fetch_ready,
    input  logic             fault_ack,
    output logic [XLEN-1:0]  pc,
    output logic             fetch_valid,
    output logic             redir_pending,
    output logic             misalign,
    output logic [XLEN-1:0]  fault_addr
);

    localparam logic [XLEN-1:0] STEP = XLEN'(1) << ALIGN_LSB;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_mis_q, pend_mis_d;

    logic [XLEN-1:0] live_target;
    logic            live_mis;
    logic            live_ok;
    logic            eff_valid;
    logic [XLEN-1:0] eff_target;
    logic            eff_mis;

    pc_target_calc #(
        .XLEN      (XLEN),
        .IMM_W     (IMM_W),
        .ALIGN_LSB (ALIGN_LSB)
    ) u_calc (
        .mode       (redir_mode),
        .base       (redir_base),
        .rs_val     (redir_reg),
        .imm        (redir_imm),
        .target     (live_target),
        .misaligned (live_mis)
    );

    // A live redirect always wins over one held from an earlier stall.
    assign live_ok    = redir_valid && (redir_mode == PC_IMM || redir_mode == PC_REG);
    assign eff_valid  = live_ok || pend_valid_q;
    assign eff_target = live_ok ? live_target : pend_target_q;
    assign eff_mis    = live_ok ? live_mis    : pend_mis_q;

    // Next-state and datapath update: redirect > sequential advance > hold.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fault_addr_d  = fault_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_mis_d    = pend_mis_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (eff_valid) begin
                    if (stall) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = eff_target;
                        pend_mis_d    = eff_mis;
                    end else begin
                        pend_valid_d = 1'b0;
                        if (eff_mis) begin
                            fault_addr_d = eff_target;
                            state_d      = FAULT;
                        end else begin
                            pc_d = eff_target;
                        end
                    end
                end else if (!stall && fetch_ready) begin
                    pc_d = pc_q + STEP;
                end
            end
            FAULT: begin
                if (fault_ack) begin
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            fault_addr_q  <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_mis_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fault_addr_q  <= fault_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_mis_q    <= pend_mis_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = (state_q == RUN);
    assign misalign      = (state_q == FAULT);
    assign redir_pending = pend_valid_q;
    assign fault_addr    = fault_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes the expected post-edge
// output snapshot after each clock edge; a monitor pops and compares on the
// falling edge.
module tb_pc_unit;

    localparam int          XLEN  = 64;
    localparam int          IMM_W = 32;
    localparam logic [63:0] RV    = 64'h1000;
    localparam logic [63:0] TV    = 64'h100;
    localparam logic [1:0]  M_IMM = 2'd1;
    localparam logic [1:0]  M_REG = 2'd2;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             redir_valid;
    logic [1:0]       redir_mode;
    logic [XLEN-1:0]  redir_base;
    logic [XLEN-1:0]  redir_reg;
    logic [IMM_W-1:0] redir_imm;
    logic             fetch_ready;
    logic             fault_ack;
    logic [XLEN-1:0]  pc;
    logic             fetch_valid;
    logic             redir_pending;
    logic             misalign;
    logic [XLEN-1:0]  fault_addr;

    pc_unit #(
        .XLEN      (XLEN),
        .IMM_W     (IMM_W),
        .RESET_VEC (RV),
        .TRAP_VEC  (TV),
        .ALIGN_LSB (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redir_valid   (redir_valid),
        .redir_mode    (redir_mode),
        .redir_base    (redir_base),
        .redir_reg     (redir_reg),
        .redir_imm     (redir_imm),
        .fetch_ready   (fetch_ready),
        .fault_ack     (fault_ack),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .redir_pending (redir_pending),
        .misalign      (misalign),
        .fault_addr    (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        fv;
        logic        pend;
        logic        mis;
        logic [63:0] fa;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare every queued expectation against the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (pc !== e.pc || fetch_valid !== e.fv || redir_pending !== e.pend ||
                misalign !== e.mis || fault_addr !== e.fa) begin
                errors++;
                $display("FAIL %s: got pc=%h fv=%b pend=%b mis=%b fa=%h, want pc=%h fv=%b pend=%b mis=%b fa=%h",
                         e.name, pc, fetch_valid, redir_pending, misalign, fault_addr,
                         e.pc, e.fv, e.pend, e.mis, e.fa);
            end
        end
    end

    task automatic idle();
        stall       = 1'b0;
        redir_valid = 1'b0;
        redir_mode  = 2'd0;
        redir_base  = '0;
        redir_reg   = '0;
        redir_imm   = '0;
        fetch_ready = 1'b0;
        fault_ack   = 1'b0;
    endtask

    task automatic redir(input logic [1:0] mode, input logic [63:0] base,
                         input logic [63:0] regv, input logic [31:0] imm);
        redir_valid = 1'b1;
        redir_mode  = mode;
        redir_base  = base;
        redir_reg   = regv;
        redir_imm   = imm;
    endtask

    // Wait for the next rising edge, queue the expected result of that edge,
    // then step off the edge so the caller can drive the next inputs.
    task automatic expect_edge(input string name, input logic [63:0] epc,
                               input logic efv, input logic epend,
                               input logic emis, input logic [63:0] efa);
        exp_t e;
        @(posedge clk);
        e = '{name, epc, efv, epend, emis, efa};
        sb.push_back(e);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        expect_edge("reset",        RV,           1'b0, 1'b0, 1'b0, 64'h0);
        rst_n = 1'b1;
        expect_edge("boot_to_run",  RV,           1'b1, 1'b0, 1'b0, 64'h0);

        fetch_ready = 1'b1;
        expect_edge("seq_1",        64'h1004,     1'b1, 1'b0, 1'b0, 64'h0);
        expect_edge("seq_2",        64'h1008,     1'b1, 1'b0, 1'b0, 64'h0);
        expect_edge("seq_3",        64'h100C,     1'b1, 1'b0, 1'b0, 64'h0);
        fetch_ready = 1'b0;
        expect_edge("hold_no_ready", 64'h100C,    1'b1, 1'b0, 1'b0, 64'h0);

        redir(M_IMM, 64'h2000, 64'h0, 32'hFFFF_FFF8);
        expect_edge("imm_neg_redir", 64'h1FF8,    1'b1, 1'b0, 1'b0, 64'h0);
        idle();
        redir(M_REG, 64'h0, 64'h3001, 32'h4);
        expect_edge("reg_bit0_clear", 64'h3004,   1'b1, 1'b0, 1'b0, 64'h0);
        redir(M_REG, 64'h0, 64'h3002, 32'h4);
        expect_edge("reg_misalign", 64'h3004,     1'b0, 1'b0, 1'b1, 64'h3006);
        redir(M_IMM, 64'h0, 64'h0, 32'h40);
        expect_edge("fault_ignores_redir", 64'h3004, 1'b0, 1'b0, 1'b1, 64'h3006);
        idle();
        fault_ack = 1'b1;
        expect_edge("fault_ack",    TV,           1'b1, 1'b0, 1'b0, 64'h3006);

        idle();
        stall = 1'b1;
        redir(M_IMM, 64'h4000, 64'h0, 32'h0);
        expect_edge("stall_pend_1", TV,           1'b1, 1'b1, 1'b0, 64'h3006);
        redir(M_IMM, 64'h5000, 64'h0, 32'h0);
        expect_edge("stall_pend_2", TV,           1'b1, 1'b1, 1'b0, 64'h3006);
        idle();
        stall = 1'b1;
        fetch_ready = 1'b1;
        expect_edge("stall_freezes_seq", TV,      1'b1, 1'b1, 1'b0, 64'h3006);
        stall = 1'b0;
        expect_edge("pend_release", 64'h5000,     1'b1, 1'b0, 1'b0, 64'h3006);

        idle();
        redir(M_IMM, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'h0);
        expect_edge("to_top",       64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0, 64'h3006);
        idle();
        fetch_ready = 1'b1;
        expect_edge("wrap_to_zero", 64'h0,        1'b1, 1'b0, 1'b0, 64'h3006);
        idle();
        redir(2'd3, 64'h7000, 64'h7000, 32'h0);
        expect_edge("bad_mode_ignored", 64'h0,    1'b1, 1'b0, 1'b0, 64'h3006);
        redir(M_IMM, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 32'h20);
        expect_edge("target_modulo", 64'h10,      1'b1, 1'b0, 1'b0, 64'h3006);

        idle();
        redir(M_IMM, 64'h0, 64'h0, 32'h2);
        expect_edge("imm_misalign", 64'h10,       1'b0, 1'b0, 1'b1, 64'h2);
        idle();
        rst_n = 1'b0;
        fault_ack = 1'b1;
        redir(M_IMM, 64'h8000, 64'h0, 32'h0);
        expect_edge("reset_in_fault", RV,         1'b0, 1'b0, 1'b0, 64'h0);
        idle();
        rst_n = 1'b1;
        expect_edge("reboot_1",     RV,           1'b1, 1'b0, 1'b0, 64'h0);

        stall = 1'b1;
        redir(M_IMM, 64'h6000, 64'h0, 32'h0);
        expect_edge("pend_before_reset", RV,      1'b1, 1'b1, 1'b0, 64'h0);
        rst_n = 1'b0;
        expect_edge("reset_in_pending", RV,       1'b0, 1'b0, 1'b0, 64'h0);
        idle();
        rst_n = 1'b1;
        expect_edge("reboot_2",     RV,           1'b1, 1'b0, 1'b0, 64'h0);
        expect_edge("no_stale_pending", RV,       1'b1, 1'b0, 1'b0, 64'h0);

        stall = 1'b1;
        redir(M_IMM, 64'h0, 64'h0, 32'h6);
        expect_edge("pend_misaligned", RV,        1'b1, 1'b1, 1'b0, 64'h0);
        idle();
        expect_edge("pend_mis_fault", RV,         1'b0, 1'b0, 1'b1, 64'h6);
        fault_ack = 1'b1;
        expect_edge("fault_ack_2",  TV,           1'b1, 1'b0, 1'b0, 64'h6);
        expect_edge("ack_ignored_in_run", TV,     1'b1, 1'b0, 1'b0, 64'h6);

        idle();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
